spi_cmd_decoder: RTL and testbench

SPI_CMD_DECODER -- requirements
Module: spi_cmd_decoder

---
 rtl/spi_cmd_decoder.sv | 190 +++++++++++++++++++
 tb/tb_spi_cmd_decoder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_decoder.sv
// spi_cmd_decoder
// Decodes one SPI command at a time and applies its effect to the LED display
// control outputs. Each command is captured when it arrives, decoded on the
// next cycle, and its effect is applied on the cycle after that.
//
// Ports
//   clk              system clock, rising edge
//   nrst             synchronous active-low reset
//   cmd_read         received command bits, last received bit at bit 0
//   cmd_len_bytes    number of received bytes
//   cmd_valid        one-cycle strobe qualifying cmd_read/cmd_len_bytes
//   cmd_write        response word for the next SPI transaction
//   rgb_enable       LED output enable
//   rotation_offset  display slice offset
//   config_data      LED driver configuration word
//   config_update    one-cycle pulse when config_data is written
//   buffer_swap      one-cycle frame buffer swap request
//
// state  | meaning
// IDLE   | waiting for cmd_valid; captures the command
// DECODE | extracts opcode, checks length range
// EXEC   | applies the command effect, counts errors
module spi_cmd_decoder #(
  parameter int unsigned N_SLICES  = 256,
  parameter logic [47:0] DEVICE_ID = 48'h535049524F53
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [63:0] cmd_read,
  input  logic [3:0]  cmd_len_bytes,
  input  logic        cmd_valid,
  output logic [47:0] cmd_write,
  output logic        rgb_enable,
  output logic [15:0] rotation_offset,
  output logic [47:0] config_data,
  output logic        config_update,
  output logic        buffer_swap
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [63:0] cmd_q, cmd_d;
  logic [3:0]  len_q, len_d;
  logic [7:0]  op_q, op_d;
  logic        len_ok_q, len_ok_d;
  logic [47:0] cw_q, cw_d;
  logic        rgb_q, rgb_d;
  logic [15:0] rot_q, rot_d;
  logic [47:0] cfg_q, cfg_d;
  logic        upd_q, upd_d;
  logic        swap_q, swap_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        ovr_q, ovr_d;

  logic [7:0]  op_sel;
  logic        err;
  logic        ovr_clr;

  // Opcode is the first byte received, i.e. the top byte of the valid span.
  always_comb begin
    op_sel = 8'h00;
    case (len_q)
      4'd1:    op_sel = cmd_q[7:0];
      4'd2:    op_sel = cmd_q[15:8];
      4'd3:    op_sel = cmd_q[23:16];
      4'd4:    op_sel = cmd_q[31:24];
      4'd5:    op_sel = cmd_q[39:32];
      4'd6:    op_sel = cmd_q[47:40];
      4'd7:    op_sel = cmd_q[55:48];
      4'd8:    op_sel = cmd_q[63:56];
      default: op_sel = 8'h00;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    len_d    = len_q;
    op_d     = op_q;
    len_ok_d = len_ok_q;
    cw_d     = cw_q;
    rgb_d    = rgb_q;
    rot_d    = rot_q;
    cfg_d    = cfg_q;
    upd_d    = 1'b0;
    swap_d   = 1'b0;
    err      = 1'b0;
    ovr_clr  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          cmd_d   = cmd_read;
          len_d   = cmd_len_bytes;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        op_d     = op_sel;
        len_ok_d = (len_q != 4'd0) && (len_q <= 4'd8);
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_IDLE;
        if (!len_ok_q) begin
          err = 1'b1;
        end else begin
          case (op_q)
            8'h00: err = (len_q != 4'd1);
            8'h01: if (len_q == 4'd1) cw_d = DEVICE_ID; else err = 1'b1;
            8'h02: if (len_q == 4'd2) rgb_d = cmd_q[0]; else err = 1'b1;
            8'h03: begin
              if (len_q != 4'd3) err = 1'b1;
              else if ({16'd0, cmd_q[15:0]} < N_SLICES) rot_d = cmd_q[15:0];
              else err = 1'b1;
            end
            8'h04: if (len_q == 4'd1) swap_d = 1'b1; else err = 1'b1;
            8'h05: begin
              if (len_q == 4'd1) begin
                // Overrun is reported as it stood before this clear.
                cw_d    = {8'hA5, err_cnt_q, op_q, 7'd0, ovr_q, 7'd0, rgb_q, 8'd0};
                ovr_clr = 1'b1;
              end else begin
                err = 1'b1;
              end
            end
            8'h06: begin
              if (len_q == 4'd7) begin
                cfg_d = cmd_q[47:0];
                upd_d = 1'b1;
              end else begin
                err = 1'b1;
              end
            end
            8'h07: if (len_q == 4'd1) cw_d = cfg_q; else err = 1'b1;
            default: err = 1'b1;
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A new overrun wins over a same-cycle clear so it is never lost.
    ovr_d     = (ovr_q && !ovr_clr) || (cmd_valid && (state_q != S_IDLE));
    err_cnt_d = (err && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q   <= S_IDLE;
      cmd_q     <= '0;
      len_q     <= '0;
      op_q      <= '0;
      len_ok_q  <= 1'b0;
      cw_q      <= '0;
      rgb_q     <= 1'b0;
      rot_q     <= '0;
      cfg_q     <= '0;
      upd_q     <= 1'b0;
      swap_q    <= 1'b0;
      err_cnt_q <= '0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      len_q     <= len_d;
      op_q      <= op_d;
      len_ok_q  <= len_ok_d;
      cw_q      <= cw_d;
      rgb_q     <= rgb_d;
      rot_q     <= rot_d;
      cfg_q     <= cfg_d;
      upd_q     <= upd_d;
      swap_q    <= swap_d;
      err_cnt_q <= err_cnt_d;
      ovr_q     <= ovr_d;
    end
  end

  assign cmd_write       = cw_q;
  assign rgb_enable      = rgb_q;
  assign rotation_offset = rot_q;
  assign config_data     = cfg_q;
  assign config_update   = upd_q;
  assign buffer_swap     = swap_q;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
module tb_spi_cmd_decoder;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [63:0] cmd_read = '0;
  logic [3:0]  cmd_len_bytes = '0;
  logic        cmd_valid = 1'b0;
  logic [47:0] cmd_write;
  logic        rgb_enable;
  logic [15:0] rotation_offset;
  logic [47:0] config_data;
  logic        config_update;
  logic        buffer_swap;

  spi_cmd_decoder #(.N_SLICES(256), .DEVICE_ID(48'h535049524F53)) dut (
    .clk(clk), .nrst(nrst), .cmd_read(cmd_read), .cmd_len_bytes(cmd_len_bytes),
    .cmd_valid(cmd_valid), .cmd_write(cmd_write), .rgb_enable(rgb_enable),
    .rotation_offset(rotation_offset), .config_data(config_data),
    .config_update(config_update), .buffer_swap(buffer_swap)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          tag;
    logic [47:0] cw;
    logic        rgb;
    logic [15:0] rot;
    logic [47:0] cfg;
    logic        upd;
    logic        swp;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  // reference model of the architecturally visible state
  logic [47:0] m_cw, m_cfg;
  logic        m_rgb, m_upd, m_swp, m_ovr;
  logic [15:0] m_rot;
  int          m_errc;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    m_cw = '0; m_cfg = '0; m_rgb = 0; m_upd = 0; m_swp = 0; m_ovr = 0;
    m_rot = '0; m_errc = 0;
  endfunction

  function automatic int req_len(logic [7:0] op);
    case (op)
      8'h00, 8'h01, 8'h04, 8'h05, 8'h07: return 1;
      8'h02: return 2;
      8'h03: return 3;
      8'h06: return 7;
      default: return -1;
    endcase
  endfunction

  function automatic void model_exec(logic [63:0] cmd, int len);
    logic [7:0]  op;
    logic [63:0] pl;
    bit          err;
    err = 0; m_upd = 0; m_swp = 0; op = 8'h00; pl = '0;
    if (len < 1 || len > 8) err = 1;
    else begin
      op = 8'(cmd >> (8 * (len - 1)));
      pl = (len == 1) ? 64'd0 : (cmd & ((64'd1 << (8 * (len - 1))) - 64'd1));
      if (req_len(op) != len) err = 1;
      else case (op)
        8'h01: m_cw = 48'h535049524F53;
        8'h02: m_rgb = pl[0];
        8'h03: if (pl < 256) m_rot = pl[15:0]; else err = 1;
        8'h04: m_swp = 1;
        8'h05: begin
          m_cw = (48'hA5 << 40) | (48'(m_errc) << 32) | (48'h05 << 24)
                 | (48'(m_ovr) << 16) | (48'(m_rgb) << 8);
          m_ovr = 0;
        end
        8'h06: begin m_cfg = pl[47:0]; m_upd = 1; end
        8'h07: m_cw = m_cfg;
        default: ;
      endcase
    end
    if (err && m_errc < 255) m_errc++;
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    while (sbq.size() > 0 && sbq[0].tag < cyc) begin
      checks++; errors++;
      $display("FAIL sb_missed tag=%0d now=%0d", sbq[0].tag, cyc);
      void'(sbq.pop_front());
    end
    if (sbq.size() > 0 && sbq[0].tag == cyc) begin
      e = sbq.pop_front();
      chk("sb_cmd_write", cmd_write, e.cw);
      chk("sb_rgb_enable", rgb_enable, e.rgb);
      chk("sb_rotation_offset", rotation_offset, e.rot);
      chk("sb_config_data", config_data, e.cfg);
      chk("sb_config_update", config_update, e.upd);
      chk("sb_buffer_swap", buffer_swap, e.swp);
    end
  end

  // Called at a falling edge; returns at the falling edge right after the
  // command's effect edge. drop=1/2 fires an extra cmd_valid one/two cycles
  // after the capture edge.
  task automatic send(logic [63:0] cmd, int len, int drop);
    int tag;
    tag = cyc + 3;
    if (drop == 1) m_ovr = 1;
    model_exec(cmd, len);
    if (drop == 2) m_ovr = 1;
    sbq.push_back('{tag, m_cw, m_rgb, m_rot, m_cfg, m_upd, m_swp});
    sbq.push_back('{tag + 1, m_cw, m_rgb, m_rot, m_cfg, 1'b0, 1'b0});
    cmd_read = cmd; cmd_len_bytes = 4'(len); cmd_valid = 1;
    @(negedge clk);
    cmd_valid = (drop == 1);
    cmd_read = {$urandom, $urandom};
    @(negedge clk);
    cmd_valid = (drop == 2);
    cmd_read = {$urandom, $urandom};
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_cmd_write"}, cmd_write, 0);
    chk({tag, "_rgb_enable"}, rgb_enable, 0);
    chk({tag, "_rotation_offset"}, rotation_offset, 0);
    chk({tag, "_config_data"}, config_data, 0);
    chk({tag, "_config_update"}, config_update, 0);
    chk({tag, "_buffer_swap"}, buffer_swap, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    nrst = 0; cmd_valid = 1;
    cmd_read = {$urandom, $urandom}; cmd_len_bytes = 4'($urandom_range(0, 15));
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    nrst = 1; cmd_valid = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_all_zero("post_reset");
  endtask

  initial begin
    logic [63:0] c;
    logic [7:0]  op;
    int          len, r, drop;
    model_reset();
    do_reset();

    send(64'h0201, 2, 0);
    chk("rgb_set", rgb_enable, 1);
    chk("rgb_cmd_write", cmd_write, 0);
    send(64'h06112233445566, 7, 0);
    chk("wcfg_data", config_data, 48'h112233445566);
    chk("wcfg_update", config_update, 1);
    send(64'h07, 1, 0);
    chk("rcfg", cmd_write, 48'h112233445566);
    send(64'h0300FF, 3, 0);
    chk("rot_255", rotation_offset, 16'd255);
    send(64'h030100, 3, 0);
    chk("rot_256_rejected", rotation_offset, 16'd255);
    send(64'h05, 1, 0);
    chk("status_err1", cmd_write, 48'hA5_01_05_00_01_00);

    do_reset();
    send(64'h7F, 1, 0);
    send(64'h02, 1, 0);
    send(64'h05, 1, 0);
    chk("status_err2", cmd_write, 48'hA5_02_05_00_00_00);
    send(64'h00, 1, 1);
    send(64'h05, 1, 0);
    chk("status_ovr_set", cmd_write, 48'hA5_02_05_01_00_00);
    send(64'h05, 1, 0);
    chk("status_ovr_clr", cmd_write, 48'hA5_02_05_00_00_00);
    send(64'h05, 1, 2);
    chk("status_same_cycle", cmd_write, 48'hA5_02_05_00_00_00);
    send(64'h05, 1, 0);
    chk("status_ovr_kept", cmd_write, 48'hA5_02_05_01_00_00);
    send(64'h04, 1, 0);
    chk("swap_pulse", buffer_swap, 1);
    send(64'h01, 1, 0);
    chk("read_id", cmd_write, 48'h535049524F53);
    send(64'h01, 0, 0);
    send(64'h01, 9, 0);
    chk("len_err_hold", cmd_write, 48'h535049524F53);
    send(64'h05, 1, 0);
    chk("status_err4", cmd_write, 48'hA5_04_05_00_00_00);

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      op = (r < 8) ? 8'(r) : 8'($urandom_range(8, 255));
      len = req_len(op);
      if (len < 0) len = 1;
      if ($urandom_range(0, 99) < 15) len = $urandom_range(0, 15);
      c = {$urandom, $urandom};
      if (len >= 1 && len <= 8) c[8*len-1 -: 8] = op;
      if (op == 8'h03 && len == 3 && $urandom_range(0, 1) == 1)
        c[15:0] = 16'($urandom_range(0, 300));
      drop = ($urandom_range(0, 99) < 10) ? $urandom_range(1, 2) : 0;
      send(c, len, drop);
    end

    // reset at the cycle after capture must leave no trace of the command
    @(negedge clk);
    cmd_read = 64'h06AABBCCDDEEFF; cmd_len_bytes = 4'd7; cmd_valid = 1;
    @(negedge clk);
    cmd_valid = 0; nrst = 0;
    repeat (2) @(negedge clk);
    nrst = 1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abandon_update", config_update, 0);
      chk("abandon_data", config_data, 0);
    end

    for (int i = 0; i < 260; i++) send(64'hFF, 1, 0);
    send(64'h05, 1, 0);
    chk("status_err_sat", cmd_write, 48'hA5_FF_05_00_00_00);

    repeat (3) @(negedge clk);
    if (sbq.size() != 0) begin
      checks++; errors++;
      $display("FAIL sb_leftover entries=%0d", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
